sigmoid_pipe: RTL and testbench
===============================

// Module: sigmoid_pipe
// PURPOSE
//  Pipelined, parametrised piecewise-linear-free sigmoid activation for the XOR NN datapath.
//  Signed fixed-point input (x = in_data/10), unsigned output in hundredths (ONE = sigmoid 1.0).
//  Uses a runtime-programmable NSEG-entry breakpoint table with odd symmetry:
//  sig(-x) = ONE - sig(x). Valid/ready streaming sits between the neuron accumulator and the next layer.
// PARAMETERS
//  IN_W   8    input width, signed two's complement
//  OUT_W  8    output width, unsigned
//  NSEG   10   breakpoint table entries (>=2)
//  ONE    100  output code for 1.0; default table values must be <= ONE
// PORTS
//  clk       in   1                 rising-edge clock
//  rst       in   1                 synchronous, active-high reset
//  in_valid  in   1                 input sample valid
//  in_ready  out  1                 input accepted when in_valid & in_ready
//  in_data   in   IN_W              signed x, units 0.1
//  out_valid out  1                 output sample valid
//  out_ready in   1                 downstream accept
//  out_data  out  OUT_W             sigmoid result, units 1/ONE
//  cfg_we    in   1                 table write strobe
//  cfg_addr  in   $clog2(NSEG)      table entry index
//  cfg_thr   in   IN_W              lower magnitude bound for entry (unsigned)
//  cfg_val   in   OUT_W             output value for entry
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, all stage valids=0; table reloads defaults:
//   thr = 0,5,10,15,20,25,30,35,40,50; val = 50,62,73,81,88,92,95,98,98,100 (NSEG>10: extra
//   entries thr=all-ones, val=ONE; NSEG<10: first NSEG entries).
//  Pipeline, 3 stages, latency 3 cycles from accept to out_valid with no stall:
//   S1: register sign and magnitude m = |in_data| (IN_W bits unsigned; -2^(IN_W-1) -> 2^(IN_W-1)).
//   S2: k = highest index i with m >= thr[i]; k=0 if none; register sign and val[k].
//   S3: out_data = sign ? ONE - val[k] : val[k]; subtraction saturates at 0 if val[k] > ONE.
//  Flow control: adv = ~out_valid | out_ready; whole pipe advances only when adv.
//   in_ready = adv & ~cfg_we. Bubbles propagate as invalid stages; no sample dropped or
//   duplicated; output order = input order. out_data holds stable while out_valid & ~out_ready.
//  Table writes: cfg_we writes thr/val[cfg_addr] at the clock edge; cfg_addr >= NSEG ignored.
//   Writes have priority over input acceptance that cycle. Samples evaluated in S2 in any
//   later cycle use the new entry; a sample in S2 on the write cycle uses the old entry.
//  Thresholds need not be monotonic; selection rule above is always applied as written.
//  Reset mid-operation: all in-flight samples discarded, out_valid=0 next cycle, table = defaults.
//  Simultaneous in accept and out accept at full pipe: throughput 1 sample/cycle sustained.
// TESTING
//  1. Defaults, no backpressure: in_data=7,0,49,50,127 -> out_data=62,50,98,100,100 at 3-cycle latency.
//  2. Symmetry: in_data=-7,-4,-128 -> 38,50,0; -5 -> 38 (m=5 selects entry 1).
//  3. Backpressure: stream 8 samples 0..35 step 5, out_ready low cycles 4-8 -> all 8 outputs
//     50,62,73,81,88,92,95,98 in order, none lost, out_data stable while stalled, in_ready=0 when full.
//  4. Table write: cfg_we addr=9 thr=60 val=99, then in 55 -> 98, 60 -> 99, -60 -> 1;
//     cfg_addr=12 (NSEG=10) -> table unchanged; in_ready=0 on write cycle.
//  5. Reset mid-flight: 3 samples in pipe, rst 1 cycle -> out_valid=0 next cycle, no stale output,
//     prior write reverted (in 60 -> 100).
//  6. Random 10k samples with random out_ready vs reference model incl. table rewrites.

Source files
------------

// File: rtl/sigmoid_pipe.sv
// sigmoid_pipe: 3-stage valid/ready sigmoid activation driven by a programmable breakpoint table.
//   The input x is signed fixed point in units of 0.1. The output is unsigned in units of 1/ONE.
//   Negative inputs use odd symmetry: sig(-x) = ONE - sig(x).
// Ports:
//   clk, rst (synchronous, active high)
//   in_valid/in_ready/in_data: signed sample in.
//   out_valid/out_ready/out_data: sigmoid result out.
//   cfg_we/cfg_addr/cfg_thr/cfg_val: table entry write. A write blocks input acceptance for that cycle.
// Latency is 3 cycles. The whole pipe freezes while out_valid & ~out_ready.
module sigmoid_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int NSEG  = 10,
  parameter int ONE   = 100,
  localparam int AW   = $clog2(NSEG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [IN_W-1:0]  cfg_thr,
  input  logic [OUT_W-1:0] cfg_val
);

  localparam logic [OUT_W-1:0] ONE_C = OUT_W'(ONE);

  // Default breakpoints. Entries beyond the tenth are never selected because of the all-ones threshold.
  function automatic logic [IN_W-1:0] def_thr(input int i);
    case (i)
      0: return IN_W'(0);
      1: return IN_W'(5);
      2: return IN_W'(10);
      3: return IN_W'(15);
      4: return IN_W'(20);
      5: return IN_W'(25);
      6: return IN_W'(30);
      7: return IN_W'(35);
      8: return IN_W'(40);
      9: return IN_W'(50);
      default: return '1;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] def_val(input int i);
    case (i)
      0: return OUT_W'(50);
      1: return OUT_W'(62);
      2: return OUT_W'(73);
      3: return OUT_W'(81);
      4: return OUT_W'(88);
      5: return OUT_W'(92);
      6: return OUT_W'(95);
      7: return OUT_W'(98);
      8: return OUT_W'(98);
      9: return OUT_W'(100);
      default: return ONE_C;
    endcase
  endfunction

  logic [IN_W-1:0]  thr [NSEG];
  logic [OUT_W-1:0] val [NSEG];

  logic             s1_vld, s1_sign;
  logic [IN_W-1:0]  s1_mag;
  logic             s2_vld, s2_sign;
  logic [OUT_W-1:0] s2_val;

  logic             adv, accept, addr_ok;
  logic [IN_W-1:0]  in_mag;
  logic [OUT_W-1:0] sel_val, s3_res;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~cfg_we;
  assign accept   = in_valid & in_ready;
  assign addr_ok  = {1'b0, cfg_addr} < (AW+1)'(NSEG);

  // The unsigned magnitude is IN_W bits wide, so the most negative input maps to 2^(IN_W-1) without overflow.
  assign in_mag = in_data[IN_W-1] ? (~in_data + 1'b1) : in_data;

  // The highest matching index wins. The thresholds may be non-monotonic, so every entry is scanned.
  always_comb begin
    sel_val = val[0];
    for (int i = 0; i < NSEG; i++) begin
      if (s1_mag >= thr[i]) sel_val = val[i];
    end
  end

  // For negative inputs the result is the complement ONE - val. It clamps to 0 when a programmed val exceeds ONE.
  always_comb begin
    s3_res = s2_val;
    if (s2_sign) s3_res = (s2_val > ONE_C) ? '0 : ONE_C - s2_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mag    <= '0;
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_val    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NSEG; i++) begin
        thr[i] <= def_thr(i);
        val[i] <= def_val(i);
      end
    end else begin
      // The table updates at this edge. A sample moving from S1 to S2 on this edge still sees the old entry.
      if (cfg_we && addr_ok) begin
        thr[cfg_addr] <= cfg_thr;
        val[cfg_addr] <= cfg_val;
      end
      if (adv) begin
        s1_vld <= accept;
        if (accept) begin
          s1_sign <= in_data[IN_W-1];
          s1_mag  <= in_mag;
        end
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_sign <= s1_sign;
          s2_val  <= sel_val;
        end
        out_valid <= s2_vld;
        if (s2_vld) out_data <= s3_res;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_pipe.sv
module tb_sigmoid_pipe;
  localparam int IN_W = 8, OUT_W = 8, NSEG = 10, ONE = 100, AW = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, cfg_we;
  logic [IN_W-1:0]  in_data, cfg_thr;
  logic [OUT_W-1:0] out_data, cfg_val;
  logic [AW-1:0]    cfg_addr;

  sigmoid_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .NSEG(NSEG), .ONE(ONE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_thr(cfg_thr), .cfg_val(cfg_val)
  );

  always #5 clk = ~clk;

  typedef struct { int v; int c; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, stall_lo = 1000000, stall_hi = 0, cur_exp = 0, held_dat = 0;
  bit rnd_mode = 0, lat_mode = 0, acc = 0, held_vld = 0;
  int m_thr [NSEG];
  int m_val [NSEG];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_thr = '{0, 5, 10, 15, 20, 25, 30, 35, 40, 50};
    m_val = '{50, 62, 73, 81, 88, 92, 95, 98, 98, 100};
  endtask

  function automatic int model(input int x);
    int m, v;
    m = (x < 0) ? -x : x;
    v = m_val[0];
    for (int i = 0; i < NSEG; i++) if (m >= m_thr[i]) v = m_val[i];
    if (x < 0) return (v > ONE) ? 0 : ONE - v;
    return v;
  endfunction

  // One clock cycle. Inputs are already set after the negedge. Handshakes are evaluated 1 ns later, then the bench waits for the edge.
  task automatic tick();
    exp_t e;
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : !(cyc >= stall_lo && cyc <= stall_hi);
    #1;
    acc = 0;
    if (!rst) begin
      if (cfg_we) chk("in_ready_on_write", in_ready, 0);
      if (out_valid && !out_ready) chk("in_ready_when_stalled", in_ready, 0);
      if (held_vld) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_dat);
      end
      held_vld = out_valid && !out_ready;
      held_dat = int'(out_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.v);
          if (lat_mode) chk("latency", cyc - e.c, 3);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{cur_exp, cyc});
        acc = 1;
      end
      if (cfg_we && int'(cfg_addr) < NSEG) begin
        m_thr[cfg_addr] = int'(cfg_thr);
        m_val[cfg_addr] = int'(cfg_val);
      end
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      held_vld = 0;
      model_reset();
    end
    cyc++;
    @(negedge clk);
    if (cyc > 90000) begin
      $display("FAIL watchdog cycles=%0d limit=90000", cyc);
      $fatal(1);
    end
  endtask

  task automatic send(input int x, input int e);
    int n = 0;
    in_data = IN_W'(x);
    in_valid = 1;
    cur_exp = e;
    do begin tick(); n++; end while (!acc && n < 50);
    if (!acc) chk("send_timeout", acc, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0;
    while (exp_q.size() > 0 && n < 200) begin tick(); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic cfg_write(input int a, input int t, input int v);
    cfg_we = 1; cfg_addr = AW'(a); cfg_thr = IN_W'(t); cfg_val = OUT_W'(v);
    tick();
    cfg_we = 0;
  endtask

  initial begin
    int n, x;
    rst = 1; in_valid = 0; in_data = '0; out_ready = 1;
    cfg_we = 0; cfg_addr = '0; cfg_thr = '0; cfg_val = '0;
    model_reset();
    tick(); tick();
    rst = 0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", in_ready, 1);

    // Default table, back to back, with no backpressure.
    lat_mode = 1;
    send(7, 62); send(0, 50); send(49, 98); send(50, 100); send(127, 100);
    drain();
    // Symmetric negative inputs.
    send(-7, 38); send(-4, 50); send(-128, 0); send(-5, 38);
    drain();
    lat_mode = 0;

    // Backpressure: out_ready is low in stream cycles 4..8.
    stall_lo = cyc + 4; stall_hi = cyc + 8;
    for (int i = 0; i < 8; i++) send(i * 5, model(i * 5));
    drain();
    chk("bp_expected_50", model(0), 50);
    stall_lo = 1000000;

    // Table write. An input presented in the same cycle must wait.
    in_valid = 1; in_data = IN_W'(55); cur_exp = 98;
    cfg_write(9, 60, 99);
    chk("write_cycle_no_accept", exp_q.size(), 0);
    send(55, 98); send(60, 99); send(-60, 1);
    drain();
    cfg_write(12, 0, 7);
    send(60, 99); send(3, 50);
    drain();

    // Reset while three samples are in flight.
    send(60, 99); send(0, 50); send(5, 62);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    for (int i = 0; i < 5; i++) tick();
    send(60, 100);
    drain();

    // Random traffic against the model, with periodic table rewrites on a drained pipe.
    rnd_mode = 1;
    n = 0;
    while (n < 10000) begin
      x = int'($urandom_range(0, 255)) - 128;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = IN_W'(x);
      cur_exp = model(x);
      tick();
      if (acc) begin
        n++;
        if (n % 1000 == 0) begin
          drain();
          for (int k = 0; k < 3; k++)
            cfg_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
